mips_seq_ctrl: RTL and testbench
================================

Name: mips_seq_ctrl

Overview:
Multi-cycle sequencer for the single-issue MIPS core. It runs each instruction through fetch, decode, execute and writeback. It does the handshake with instruction memory, samples the opcode/func decoder outputs, and drives the per-cycle enables for the PC, IR, ALU and register file. It halts on illegal instructions (decoder alu_ctrl = 12'hFFF) and on a fetch timeout.

Parameters:
FETCH_TIMEOUT, 255, max cycles FETCH waits for imem_ack before fault; 0 disables the timeout
ILLEGAL_CTRL, 12'hFFF, decoder alu_ctrl value meaning unsupported instruction

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
run  in  1  level; start/continue execution from IDLE
stop  in  1  level; return to IDLE after current WB
clear  in  1  pulse; leave HALT
imem_req  out  1  fetch request, held high throughout FETCH
imem_ack  in  1  instruction word valid this cycle
opcode  in  6  instr[31:26] from IR
dec_write_reg  in  1  decoder register-write flag
dec_alu_ctrl  in  12  decoder ALU control
ir_we  out  1  load IR this cycle
pc_we  out  1  advance PC this cycle
alu_en  out  1  ALU operands/result valid this cycle
alu_ctrl  out  12  latched ALU control
alu_src_imm  out  1  1 = ALU operand B from sign-extended immediate
reg_dst_rd  out  1  1 = destination rd, 0 = rt
rf_we  out  1  register-file write strobe
halted  out  1  high in HALT
fault  out  2  00 none, 01 illegal instr, 10 fetch timeout
state  out  3  current state, for debug

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0: alu_ctrl=0, fault=00, timeout counter=0.
  - Deassertion is sampled on clk.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5.
  - Encodings 6 and 7 are unreachable and go to HALT with fault=01.
- IDLE: run=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1 (combinational from state).
  - imem_ack=1 -> ir_we=1 in the same cycle; next state DECODE; counter cleared.
  - Otherwise the counter increments. When the counter reaches FETCH_TIMEOUT (nonzero) with no ack -> HALT, fault=10.
  - An ack on the timeout cycle wins: go to DECODE.
- DECODE:
  - Register alu_ctrl<=dec_alu_ctrl, write flag<=dec_write_reg, alu_src_imm<=(opcode!=0), reg_dst_rd<=(opcode==0).
  - dec_alu_ctrl==ILLEGAL_CTRL -> HALT, fault=01, no PC advance. Otherwise -> EXEC.
- EXEC: alu_en=1 for exactly one cycle -> WB.
- WB:
  - rf_we = latched write flag; pc_we=1; both for one cycle.
  - stop=1 -> IDLE. Otherwise FETCH (run is not rechecked).
- HALT:
  - halted=1; fault held.
  - clear=1 -> IDLE, fault<=00. Only a reset or clear exits HALT.
- Latency: 4 cycles per instruction with zero-wait memory; +N cycles for N wait states.
- ir_we, pc_we, alu_en, rf_we are single-cycle strobes and never overlap.
- imem_ack outside FETCH is ignored. clear outside HALT is ignored. stop is sampled only in WB.
- run and stop both high in WB -> IDLE. run is still high, so IDLE re-enters FETCH next cycle.
- Reset mid-FETCH drops imem_req immediately (async). Memory must tolerate an abandoned request.

Optional Feature:
- Macro MIPS_SEQ_CTRL_PERF_EN.
- Defined:
  - Adds outputs retired_cnt[31:0] (increments on each WB cycle) and stall_cnt[31:0] (increments on each FETCH cycle with imem_ack=0).
  - Both counters wrap at 2^32 and reset to 0.
  - Neither counter changes in HALT or IDLE.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - enum seq_state_t (IDLE..HALT, 3 bits);
  - fault_t (FAULT_NONE, FAULT_ILLEGAL, FAULT_TIMEOUT);
  - OPCODE_RTYPE=6'b000000;
  - ALU_CTRL_ILLEGAL=12'hFFF, which the decoder should also use.
- One sub-module, mips_fetch_timer: the saturating timeout counter with clear/enable and an expired flag. Everything else stays in mips_seq_ctrl.

Test Plan:
- Reset then run=1, imem_ack always 1, ADDU (opcode 0, alu_ctrl 12'h021, write 1) -> states 1,2,3,4 repeat every 4 cycles; rf_we and pc_we in WB; reg_dst_rd=1; alu_src_imm=0.
- ADDI (opcode 6'b001000, alu_ctrl 12'h200) -> alu_src_imm=1, reg_dst_rd=0, rf_we=1 in WB.
- imem_ack delayed 3 cycles -> FETCH lasts 4 cycles; ir_we exactly one cycle, coincident with ack; stall_cnt=3 with PERF_EN.
- dec_alu_ctrl=12'hFFF in DECODE -> HALT next cycle; fault=01; no pc_we; clear pulse -> IDLE with fault=00.
- FETCH_TIMEOUT=4, imem_ack held 0 -> HALT after 4 FETCH cycles with fault=10. Repeat with ack on cycle 4 -> DECODE.
- rst_n low mid-EXEC -> outputs 0 asynchronously (before the next clk edge); after release with run=1 -> FETCH; retired_cnt=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS multi-cycle core.
// The ALU_CTRL_ILLEGAL code is shared with the opcode/func decoder.
package mips_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_TIMEOUT = 2'b10
  } fault_t;

  localparam logic [5:0]  OPCODE_RTYPE     = 6'b000000;
  localparam logic [11:0] ALU_CTRL_ILLEGAL = 12'hFFF;

endpackage

// File: rtl/mips_fetch_timer.sv
// Saturating fetch-wait counter; expired_o flags the last allowed
// wait cycle. LIMIT=0 never expires.
module mips_fetch_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW =
    (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CW-1:0] LAST =
    CW'((LIMIT == 0) ? 0 : LIMIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && cnt_q != LAST)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // expires on the LIMIT-th waiting cycle, before the counter moves
  assign expired_o = (LIMIT != 0) && en_i
                     && (cnt_q == LAST);

endmodule

// File: rtl/mips_seq_ctrl.sv
// Fetch/decode/exec/writeback sequencer for the multi-cycle MIPS core.
// Define MIPS_SEQ_CTRL_PERF_EN to add retired/stall counters.
module mips_seq_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 255,
  parameter logic [11:0] ILLEGAL_CTRL  = ALU_CTRL_ILLEGAL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        stop,
  input  logic        clear,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [5:0]  opcode,
  input  logic        dec_write_reg,
  input  logic [11:0] dec_alu_ctrl,
  output logic        ir_we,
  output logic        pc_we,
  output logic        alu_en,
  output logic [11:0] alu_ctrl,
  output logic        alu_src_imm,
  output logic        reg_dst_rd,
  output logic        rf_we,
  output logic        halted,
  output logic [1:0]  fault,
  output logic [2:0]  state
`ifdef MIPS_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [2:0] ST_IDLE   = S_IDLE;
  localparam logic [2:0] ST_FETCH  = S_FETCH;
  localparam logic [2:0] ST_DECODE = S_DECODE;
  localparam logic [2:0] ST_EXEC   = S_EXEC;
  localparam logic [2:0] ST_WB     = S_WB;
  localparam logic [2:0] ST_HALT   = S_HALT;

  logic [2:0]  state_q, state_d;
  logic [1:0]  fault_q, fault_d;
  logic [11:0] alu_ctrl_q;
  logic        wr_q;
  logic        imm_q;
  logic        rd_q;
  logic        in_fetch;
  logic        tmr_expired;

  assign in_fetch = (state_q == ST_FETCH);

  mips_fetch_timer #(
    .LIMIT (FETCH_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (!in_fetch || imem_ack),
    .en_i      (in_fetch),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    unique case (state_q)
      ST_IDLE:
        if (run) state_d = ST_FETCH;
      ST_FETCH:
        if (imem_ack) begin
          state_d = ST_DECODE;
        end else if (tmr_expired) begin
          state_d = ST_HALT;
          fault_d = FAULT_TIMEOUT;
        end
      ST_DECODE:
        if (dec_alu_ctrl == ILLEGAL_CTRL) begin
          state_d = ST_HALT;
          fault_d = FAULT_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      ST_EXEC:
        state_d = ST_WB;
      ST_WB:
        state_d = stop ? ST_IDLE : ST_FETCH;
      ST_HALT:
        if (clear) begin
          state_d = ST_IDLE;
          fault_d = FAULT_NONE;
        end
      default: begin
        state_d = ST_HALT;
        fault_d = FAULT_ILLEGAL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl_q <= '0;
      wr_q       <= 1'b0;
      imm_q      <= 1'b0;
      rd_q       <= 1'b0;
    end else if (state_q == ST_DECODE) begin
      alu_ctrl_q <= dec_alu_ctrl;
      wr_q       <= dec_write_reg;
      imm_q      <= (opcode != OPCODE_RTYPE);
      rd_q       <= (opcode == OPCODE_RTYPE);
    end
  end

  assign imem_req    = in_fetch;
  assign ir_we       = in_fetch && imem_ack;
  assign alu_en      = (state_q == ST_EXEC);
  assign pc_we       = (state_q == ST_WB);
  assign rf_we       = (state_q == ST_WB) && wr_q;
  assign halted      = (state_q == ST_HALT);
  assign fault       = fault_q;
  assign state       = state_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign alu_src_imm = imm_q;
  assign reg_dst_rd  = rd_q;

`ifdef MIPS_SEQ_CTRL_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (state_q == ST_WB)
        retired_q <= retired_q + 32'd1;
      if (in_fetch && !imem_ack)
        stall_q <= stall_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Self-checking bench for mips_seq_ctrl: directed table, corner
// sequences and randomized traffic against a behavioural model.
module tb_mips_seq_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        imem_ack = 1'b0;
  logic [5:0]  opcode = '0;
  logic        dec_write_reg = 1'b0;
  logic [11:0] dec_alu_ctrl = '0;
  logic        imem_req, ir_we, pc_we, alu_en;
  logic [11:0] alu_ctrl;
  logic        alu_src_imm, reg_dst_rd, rf_we, halted;
  logic [1:0]  fault;
  logic [2:0]  state;
`ifdef MIPS_SEQ_CTRL_PERF_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  mips_seq_ctrl #(
    .FETCH_TIMEOUT (TO),
    .ILLEGAL_CTRL  (12'hFFF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .stop          (stop),
    .clear         (clear),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .opcode        (opcode),
    .dec_write_reg (dec_write_reg),
    .dec_alu_ctrl  (dec_alu_ctrl),
    .ir_we         (ir_we),
    .pc_we         (pc_we),
    .alu_en        (alu_en),
    .alu_ctrl      (alu_ctrl),
    .alu_src_imm   (alu_src_imm),
    .reg_dst_rd    (reg_dst_rd),
    .rf_we         (rf_we),
    .halted        (halted),
    .fault         (fault),
    .state         (state)
`ifdef MIPS_SEQ_CTRL_PERF_EN
    ,
    .retired_cnt   (retired_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // behavioural model: phase number, sticky fault, latched decode
  int          m_st;
  int          m_wait;
  logic [1:0]  m_fault;
  logic [11:0] m_alu;
  logic        m_wr, m_imm, m_rd;
  logic [31:0] m_ret, m_stall;

  task automatic m_reset();
    m_st = 0; m_wait = 0; m_fault = 2'b00;
    m_alu = '0; m_wr = 0; m_imm = 0; m_rd = 0;
    m_ret = '0; m_stall = '0;
  endtask

  function automatic logic [24:0] m_outs(input logic ack);
    logic fe;
    fe = (m_st == 1);
    return {fe, fe && ack, m_st == 4, m_st == 3, m_alu,
            m_imm, m_rd, (m_st == 4) && m_wr, m_st == 5,
            m_fault, 3'(m_st)};
  endfunction

  task automatic m_tick(input logic r, s, c, a,
                        input logic [5:0] op,
                        input logic w, input logic [11:0] al);
    case (m_st)
      0: if (r) m_st = 1;
      1: if (a) begin
           m_st = 2; m_wait = 0;
         end else begin
           m_stall++; m_wait++;
           if (m_wait == TO) begin
             m_st = 5; m_fault = 2'b10; m_wait = 0;
           end
         end
      2: begin
           m_alu = al; m_wr = w;
           m_imm = (op != 0); m_rd = (op == 0);
           if (al == 12'hFFF) begin
             m_st = 5; m_fault = 2'b01;
           end else m_st = 3;
         end
      3: m_st = 4;
      4: begin m_ret++; m_st = s ? 0 : 1; end
      5: if (c) begin m_st = 0; m_fault = 2'b00; end
      default: m_st = 5;
    endcase
  endtask

  wire [24:0] outs_act = {imem_req, ir_we, pc_we, alu_en, alu_ctrl,
                          alu_src_imm, reg_dst_rd, rf_we, halted,
                          fault, state};

  logic [2:0] s_st;
  logic [5:0] s_strb;
  logic       s_imm, s_rd;
  int         ir_cnt, pc_cnt, fe_cnt;

  task automatic check_perf();
`ifdef MIPS_SEQ_CTRL_PERF_EN
    check("retired_cnt", 64'(retired_cnt), 64'(m_ret));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  // drive at posedge+1, compare at negedge, advance model at posedge
  task automatic step(input logic r, s, c, a,
                      input logic [5:0] op,
                      input logic w, input logic [11:0] al);
    run = r; stop = s; clear = c; imem_ack = a;
    opcode = op; dec_write_reg = w; dec_alu_ctrl = al;
    @(negedge clk);
    check("outs", 64'(outs_act), 64'(m_outs(a)));
    check_perf();
    s_st = state; s_imm = alu_src_imm; s_rd = reg_dst_rd;
    s_strb = {imem_req, ir_we, alu_en, pc_we, rf_we, halted};
    ir_cnt += int'(ir_we);
    pc_cnt += int'(pc_we);
    fe_cnt += int'(state == 3'd1);
    @(posedge clk);
    m_tick(r, s, c, a, op, w, al);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    check("reset_outs", 64'(outs_act), 64'(m_outs(1'b0)));
    check_perf();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic r, s, a;
    logic [5:0] op;
    logic w;
    logic [11:0] al;
    logic [2:0] st;
    logic [5:0] strb;
    logic imm, rd;
  } vec_t;

  function automatic vec_t mk(input logic r, s, a,
                              input logic [5:0] op, input logic w,
                              input logic [11:0] al,
                              input logic [2:0] st,
                              input logic [5:0] strb,
                              input logic imm, rd);
    vec_t v;
    v.r = r; v.s = s; v.a = a; v.op = op; v.w = w; v.al = al;
    v.st = st; v.strb = strb; v.imm = imm; v.rd = rd;
    return v;
  endfunction

  vec_t vecs[11];

  initial begin
    // strb = {imem_req, ir_we, alu_en, pc_we, rf_we, halted}
    vecs[0]  = mk(1, 0, 1, 6'h00, 1, 12'h021, 0, 6'b000000, 0, 0);
    vecs[1]  = mk(1, 0, 1, 6'h00, 1, 12'h021, 1, 6'b110000, 0, 0);
    vecs[2]  = mk(1, 0, 1, 6'h00, 1, 12'h021, 2, 6'b000000, 0, 0);
    vecs[3]  = mk(1, 0, 1, 6'h00, 1, 12'h021, 3, 6'b001000, 0, 1);
    vecs[4]  = mk(1, 0, 1, 6'h00, 1, 12'h021, 4, 6'b000110, 0, 1);
    vecs[5]  = mk(1, 0, 1, 6'h08, 1, 12'h200, 1, 6'b110000, 0, 1);
    vecs[6]  = mk(1, 0, 1, 6'h08, 1, 12'h200, 2, 6'b000000, 0, 1);
    vecs[7]  = mk(1, 0, 1, 6'h08, 1, 12'h200, 3, 6'b001000, 1, 0);
    vecs[8]  = mk(1, 1, 1, 6'h08, 1, 12'h200, 4, 6'b000110, 1, 0);
    vecs[9]  = mk(0, 0, 1, 6'h08, 1, 12'h200, 0, 6'b000000, 1, 0);
    vecs[10] = mk(0, 0, 1, 6'h08, 1, 12'h200, 0, 6'b000000, 1, 0);

    do_reset();

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].r, vecs[i].s, 1'b0, vecs[i].a,
           vecs[i].op, vecs[i].w, vecs[i].al);
      check($sformatf("tbl%0d_state", i), 64'(s_st), 64'(vecs[i].st));
      check($sformatf("tbl%0d_strb", i), 64'(s_strb),
            64'(vecs[i].strb));
      check($sformatf("tbl%0d_imm_rd", i), 64'({s_imm, s_rd}),
            64'({vecs[i].imm, vecs[i].rd}));
    end

    // three wait states: FETCH lasts 4 cycles, one ir_we on the ack
    do_reset();
    step(1, 0, 0, 0, 6'h00, 1, 12'h021);
    ir_cnt = 0; fe_cnt = 0;
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 6'h00, 1, 12'h021);
    step(0, 0, 0, 1, 6'h00, 1, 12'h021);
    check("wait_ir_on_ack", 64'(s_strb[4]), 64'(1));
    check("wait_fetch_len", 64'(fe_cnt), 64'(4));
    check("wait_ir_once", 64'(ir_cnt), 64'(1));
`ifdef MIPS_SEQ_CTRL_PERF_EN
    check("wait_stall3", 64'(stall_cnt), 64'(3));
`endif
    step(0, 0, 0, 0, 6'h00, 1, 12'h021);
    step(0, 0, 0, 0, 6'h00, 1, 12'h021);
    step(0, 1, 0, 0, 6'h00, 1, 12'h021);
    check("wait_idle", 64'(state), 64'(0));

    // illegal instruction halts without a PC advance
    pc_cnt = 0;
    step(1, 0, 0, 1, 6'h00, 1, 12'hFFF);
    step(1, 0, 0, 1, 6'h00, 1, 12'hFFF);
    step(1, 0, 0, 1, 6'h00, 1, 12'hFFF);
    check("ill_state", 64'(state), 64'(5));
    check("ill_fault", 64'(fault), 64'(1));
    step(1, 1, 0, 1, 6'h00, 1, 12'h021);
    step(1, 1, 0, 1, 6'h00, 1, 12'h021);
    check("ill_held", 64'({halted, fault}), 64'(3'b101));
    check("ill_no_pc", 64'(pc_cnt), 64'(0));
    step(0, 0, 1, 0, 6'h00, 1, 12'h021);
    check("ill_clear", 64'({state, fault}), 64'(5'b000_00));

    // fetch timeout after 4 unanswered cycles
    step(1, 0, 0, 0, 6'h00, 1, 12'h021);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 6'h00, 1, 12'h021);
    check("to_still_fetch", 64'(state), 64'(1));
    step(0, 0, 0, 0, 6'h00, 1, 12'h021);
    check("to_halt", 64'({state, fault}), 64'(5'b101_10));
    step(0, 0, 1, 0, 6'h00, 1, 12'h021);
    check("to_clear", 64'({state, fault}), 64'(5'b000_00));

    // ack arriving on the timeout cycle wins
    step(1, 0, 0, 0, 6'h00, 1, 12'h021);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 6'h00, 1, 12'h021);
    step(0, 0, 0, 1, 6'h00, 1, 12'h021);
    check("to_ack_wins", 64'({state, fault}), 64'(5'b010_00));
    step(0, 0, 0, 0, 6'h00, 1, 12'h021);
    check("to_exec", 64'(state), 64'(3));

    // asynchronous reset in EXEC
    #2 rst_n = 1'b0;
    #1;
    check("arst_outs", 64'(outs_act), 64'(0));
`ifdef MIPS_SEQ_CTRL_PERF_EN
    check("arst_retired", 64'(retired_cnt), 64'(0));
`endif
    m_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 0, 0, 1, 6'h00, 1, 12'h021);
    check("arst_fetch", 64'(state), 64'(1));
`ifdef MIPS_SEQ_CTRL_PERF_EN
    check("arst_retired0", 64'(retired_cnt), 64'(0));
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [11:0] al;
      logic [5:0]  op;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        al = ($urandom_range(0, 9) == 0) ? 12'hFFF
                                         : 12'($urandom);
        op = ($urandom_range(0, 4) < 2) ? 6'h00 : 6'($urandom);
        step($urandom_range(0, 3) != 0,
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 4) == 0,
             $urandom_range(0, 9) < 7,
             op, 1'($urandom), al);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
